// File: rtl/led_pattern_pkg.sv
// Shared definitions for the status-LED arbiter: pattern codes, arbiter states
// and the lowest-index priority encoder.
package led_pattern_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_SLOW  = 2'd2;
    localparam logic [1:0] MODE_FAST  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        prio_enc = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                prio_enc = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Free-running prescaler: counts 0..DIV-1 and flags the last count as the tick.
module led_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick_o = (cnt_reg == LAST);

endmodule

// File: rtl/led_pattern_arbiter.sv
// Fixed-priority owner selection with a minimum-hold rule for the single
// board status LED, plus rendering of the owner's blink pattern.
module led_pattern_arbiter
    import led_pattern_pkg::*;
#(
    parameter int CLK_HZ          = 25_000_000,
    parameter int TICK_HZ         = 10,
    parameter int N_REQ           = 4,
    parameter int MIN_HOLD_TICKS  = 10,
    parameter int SLOW_HALF_TICKS = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [2*N_REQ-1:0]   mode_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 led_o,
    output logic                 tick_o
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W  = $clog2(MIN_HOLD_TICKS + 1);
    localparam int PHASE_W = (2 * SLOW_HALF_TICKS > 1) ? $clog2(2 * SLOW_HALF_TICKS) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(MIN_HOLD_TICKS);
    localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(SLOW_HALF_TICKS);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * SLOW_HALF_TICKS - 1);

    logic                tick;
    state_e              state_reg, state_next;
    logic [IDX_W-1:0]    own_reg, own_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic [PHASE_W-1:0]  phase_reg, phase_next;
    logic [1:0]          mode_reg, mode_next;
    logic [N_REQ-1:0]    grant_reg, grant_next;
    logic                led_reg, led_next;

    logic [1:0]          mode_arr [N_REQ];
    logic [N_REQ-1:0]    higher_mask;
    logic [IDX_W-1:0]    lowest_idx;
    logic                any_req;
    logic                do_grant;

    led_tick_div #(.DIV(DIV)) u_tick_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign mode_arr[gi]    = mode_i[2*gi +: 2];
            assign higher_mask[gi] = req_i[gi] && (IDX_W'(gi) < own_reg);
            assign grant_next[gi]  = (state_next == ST_OWN) && (own_next == IDX_W'(gi));
        end
    endgenerate

    assign any_req    = |req_i;
    assign lowest_idx = IDX_W'(prio_enc(8'(req_i)));

    always_comb begin
        state_next = state_reg;
        own_next   = own_reg;
        hold_next  = hold_reg;
        phase_next = phase_reg;
        mode_next  = mode_reg;
        do_grant   = 1'b0;
        if (tick) begin
            case (state_reg)
                ST_IDLE: begin
                    do_grant = any_req;
                end
                ST_OWN: begin
                    if (!req_i[own_reg]) begin
                        // A dropping owner hands over at once, regardless of hold.
                        if (any_req) begin
                            do_grant = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else if ((|higher_mask) && (hold_reg == HOLD_MAX)) begin
                        do_grant = 1'b1;
                    end else begin
                        if (hold_reg != HOLD_MAX) begin
                            hold_next = hold_reg + 1'b1;
                        end
                        phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
                        mode_next  = mode_arr[own_reg];
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
        if (do_grant) begin
            state_next = ST_OWN;
            own_next   = lowest_idx;
            hold_next  = HOLD_W'(1);
            phase_next = '0;
            mode_next  = mode_arr[lowest_idx];
        end
    end

    // Rendered from the next-state values so LED and grant change on the same edge.
    always_comb begin
        led_next = 1'b0;
        if (state_next == ST_OWN) begin
            case (mode_next)
                MODE_SOLID: led_next = 1'b1;
                MODE_SLOW:  led_next = (phase_next < PHASE_HALF);
                MODE_FAST:  led_next = ~phase_next[0];
                default:    led_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            own_reg   <= '0;
            hold_reg  <= '0;
            phase_reg <= '0;
            mode_reg  <= MODE_OFF;
            grant_reg <= '0;
            led_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            own_reg   <= own_next;
            hold_reg  <= hold_next;
            phase_reg <= phase_next;
            mode_reg  <= mode_next;
            grant_reg <= grant_next;
            led_reg   <= led_next;
        end
    end

    assign grant_o = grant_reg;
    assign led_o   = led_reg;
    assign tick_o  = tick;

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Scoreboard bench for led_pattern_arbiter with DIV=4, MIN_HOLD_TICKS=3,
// SLOW_HALF_TICKS=2: expectations are queued per decision and checked on tick edges.
module tb_led_pattern_arbiter;

    localparam logic [1:0] OFF   = 2'd0;
    localparam logic [1:0] SOLID = 2'd1;
    localparam logic [1:0] SLOW  = 2'd2;
    localparam logic [1:0] FAST  = 2'd3;

    typedef struct {
        logic [3:0] g;
        logic       l;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [7:0] mode = 8'h00;
    logic [3:0] grant;
    logic       led;
    logic       tick;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    led_pattern_arbiter #(
        .CLK_HZ(40), .TICK_HZ(10), .N_REQ(4),
        .MIN_HOLD_TICKS(3), .SLOW_HALF_TICKS(2)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .mode_i  (mode),
        .grant_o (grant),
        .led_o   (led),
        .tick_o  (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] md(input logic [1:0] m3, input logic [1:0] m2,
                                      input logic [1:0] m1, input logic [1:0] m0);
        return {m3, m2, m1, m0};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: each decision edge (tick high, not in reset) pops one expectation.
    initial begin
        logic t, r;
        exp_t e;
        forever begin
            @(negedge clk);
            t = tick;
            r = rst;
            @(posedge clk);
            #1;
            if (t && !r) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_decision: grant=%b led=%b with empty scoreboard", grant, led);
                end else begin
                    e = exp_q.pop_front();
                    if (grant !== e.g || led !== e.l) begin
                        n_bad++;
                        $display("FAIL %s: grant=%b led=%b, expected grant=%b led=%b",
                                 e.name, grant, led, e.g, e.l);
                    end else begin
                        $display("ok   %s: grant=%b led=%b", e.name, grant, led);
                    end
                end
            end
        end
    end

    // Waits through the next decision edge; returns the number of edges consumed.
    task automatic wait_decision(output int n);
        logic t;
        t = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            t = tick;
            @(posedge clk);
            n++;
            if (t) break;
        end
        if (!t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tick_timeout: no tick within %0d edges", n);
        end
        #2;
    endtask

    task automatic step(input logic [3:0] r, input logic [7:0] m, input logic [3:0] g,
                        input logic l, input string name, input int exp_edges);
        exp_t e;
        int n;
        req  = r;
        mode = m;
        e.g = g;
        e.l = l;
        e.name = name;
        exp_q.push_back(e);
        wait_decision(n);
        chk({name, "_edges"}, n, exp_edges);
    endtask

    initial begin
        exp_t e;
        logic [7:0] mh;
        logic [7:0] ms;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_tick", int'(tick), 0);
        rst = 1'b0;

        // Basic grant: nothing visible before the 4th edge after release
        req  = 4'b0001;
        mode = md(OFF, OFF, OFF, SOLID);
        e.g = 4'b0001; e.l = 1'b1; e.name = "basic_grant";
        exp_q.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_grant_grant", int'(grant), 0);
        chk("pre_grant_led", int'(led), 0);
        chk("first_tick", int'(tick), 1);
        @(posedge clk);
        #2;
        step(4'b0001, md(OFF, OFF, OFF, SOLID), 4'b0001, 1'b1, "solid_keep", 4);

        // FAST then SLOW on requester 1; phase continues across the mode change
        step(4'b0010, md(OFF, OFF, FAST, OFF), 4'b0010, 1'b1, "fast_p0", 4);
        step(4'b0010, md(OFF, OFF, FAST, OFF), 4'b0010, 1'b0, "fast_p1", 4);
        step(4'b0010, md(OFF, OFF, FAST, OFF), 4'b0010, 1'b1, "fast_p2", 4);
        step(4'b0010, md(OFF, OFF, FAST, OFF), 4'b0010, 1'b0, "fast_p3", 4);
        step(4'b0010, md(OFF, OFF, SLOW, OFF), 4'b0010, 1'b1, "slow_p0", 4);
        step(4'b0010, md(OFF, OFF, SLOW, OFF), 4'b0010, 1'b1, "slow_p1", 4);
        step(4'b0010, md(OFF, OFF, SLOW, OFF), 4'b0010, 1'b0, "slow_p2", 4);
        step(4'b0010, md(OFF, OFF, SLOW, OFF), 4'b0010, 1'b0, "slow_p3", 4);
        step(4'b0010, md(OFF, OFF, SLOW, OFF), 4'b0010, 1'b1, "slow_wrap", 4);
        step(4'b0000, 8'h00, 4'b0000, 1'b0, "to_idle", 4);

        // A request pulse between ticks is never seen
        req  = 4'b0001;
        mode = md(OFF, OFF, OFF, SOLID);
        @(posedge clk);
        #1;
        req = 4'b0000;
        step(4'b0000, 8'h00, 4'b0000, 1'b0, "glitch_ignored", 3);

        // Hold-off: req0 must wait until req2 has held for 3 ticks
        mh = md(OFF, SOLID, OFF, FAST);
        step(4'b0100, mh, 4'b0100, 1'b1, "hold_T0", 4);
        step(4'b0101, mh, 4'b0100, 1'b1, "hold_T1", 4);
        step(4'b0101, mh, 4'b0100, 1'b1, "hold_T2", 4);
        step(4'b0101, mh, 4'b0001, 1'b1, "preempt_T3", 4);
        step(4'b0101, mh, 4'b0001, 1'b0, "fast_after_preempt", 4);
        step(4'b1101, md(SOLID, SOLID, OFF, FAST), 4'b0001, 1'b1, "low_no_preempt", 4);
        step(4'b0000, 8'h00, 4'b0000, 1'b0, "idle2", 4);

        // Release / handover to a pending lower-priority requester
        ms = md(SOLID, SOLID, SOLID, SOLID);
        step(4'b0100, ms, 4'b0100, 1'b1, "rel_grant", 4);
        step(4'b1100, ms, 4'b0100, 1'b1, "rel_pending", 4);
        step(4'b1000, ms, 4'b1000, 1'b1, "rel_handover", 4);
        step(4'b0000, ms, 4'b0000, 1'b0, "rel_idle", 4);

        // Simultaneous events resolve to the lowest index
        step(4'b1010, ms, 4'b0010, 1'b1, "simul_from_idle", 4);
        step(4'b1001, ms, 4'b0001, 1'b1, "drop_plus_higher", 4);

        // Reset mid-operation
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_led", int'(led), 0);
        chk("midrst_tick", int'(tick), 0);
        rst = 1'b0;
        step(4'b1001, ms, 4'b0001, 1'b1, "post_reset_grant", 4);

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
